// File: rtl/decoder_2x4.sv
// Registered 2-to-4 line decoder with enable and selectable output polarity.
// Define DECODER_2X4_STATUS_EN to add the sel_idx/sel_vld status outputs.
module decoder_2x4 #(
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4
`ifdef DECODER_2X4_STATUS_EN
  ,
  output logic [1:0] sel_idx,
  output logic       sel_vld
`endif
);

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;
  localparam logic [NUM_OUT-1:0] INACTIVE = ACTIVE_LOW_OUT ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] onehot_next;
  logic [NUM_OUT-1:0] out_next;
  logic [NUM_OUT-1:0] out_q;

  assign sel = {a, b};

  // Active-high one-hot decode, then fold in the output polarity.
  always_comb begin
    onehot_next = '0;
    if (en) begin
      onehot_next[sel] = 1'b1;
    end
    out_next = ACTIVE_LOW_OUT ? ~onehot_next : onehot_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= INACTIVE;
    end else begin
      out_q <= out_next;
    end
  end

  assign d1 = out_q[0];
  assign d2 = out_q[1];
  assign d3 = out_q[2];
  assign d4 = out_q[3];

`ifdef DECODER_2X4_STATUS_EN
  logic [SEL_W-1:0] sel_idx_q;
  logic             sel_vld_q;

  // Index holds the last enabled code; valid tracks en with the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx_q <= '0;
      sel_vld_q <= 1'b0;
    end else begin
      sel_vld_q <= en;
      if (en) begin
        sel_idx_q <= sel;
      end
    end
  end

  assign sel_idx = sel_idx_q;
  assign sel_vld = sel_vld_q;
`endif

endmodule

// File: tb/tb_decoder_2x4.sv
// Self-checking bench for decoder_2x4: both polarities driven in parallel,
// directed plan steps followed by randomized steps against a behavioural model.
module tb_decoder_2x4;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic en;
  logic h1, h2, h3, h4;
  logic l1, l2, l3, l4;
`ifdef DECODER_2X4_STATUS_EN
  logic [1:0] h_idx, l_idx;
  logic       h_vld, l_vld;
`endif

  int compared;
  int mismatched;

  // Model state
  logic [3:0] exp_h;
  logic [1:0] exp_idx;
  logic       exp_vld;

  decoder_2x4 #(.ACTIVE_LOW_OUT(1'b0)) dut_h (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .d1(h1), .d2(h2), .d3(h3), .d4(h4)
`ifdef DECODER_2X4_STATUS_EN
    , .sel_idx(h_idx), .sel_vld(h_vld)
`endif
  );

  decoder_2x4 #(.ACTIVE_LOW_OUT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .d1(l1), .d2(l2), .d3(l3), .d4(l4)
`ifdef DECODER_2X4_STATUS_EN
    , .sel_idx(l_idx), .sel_vld(l_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/high"}, {h1, h2, h3, h4}, exp_h);
    check({tag, "/low"},  {l1, l2, l3, l4}, ~exp_h);
`ifdef DECODER_2X4_STATUS_EN
    check({tag, "/idx_h"}, 4'(h_idx), 4'(exp_idx));
    check({tag, "/vld_h"}, 4'(h_vld), 4'(exp_vld));
    check({tag, "/idx_l"}, 4'(l_idx), 4'(exp_idx));
    check({tag, "/vld_l"}, 4'(l_vld), 4'(exp_vld));
`endif
  endtask

  // Drive one set of inputs, clock once, update model, compare.
  task automatic step(input string tag, input logic r, input logic ia, input logic ib, input logic ie);
    int code;
    rst = r;
    a   = ia;
    b   = ib;
    en  = ie;
    @(posedge clk);
    #1;
    code = 2 * int'(ia) + int'(ib);
    if (r) begin
      exp_h   = 4'b0000;
      exp_idx = 2'b00;
      exp_vld = 1'b0;
    end else if (ie) begin
      // d1 is the MSB of the checked vector and corresponds to code 0
      exp_h   = 4'b1000 >> code;
      exp_idx = 2'(code);
      exp_vld = 1'b1;
    end else begin
      exp_h   = 4'b0000;
      exp_vld = 1'b0;
    end
    check_all(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_h      = 4'b0000;
    exp_idx    = 2'b00;
    exp_vld    = 1'b0;
    rst = 1'b1; a = 1'b1; b = 1'b1; en = 1'b1;

    step("reset0", 1'b1, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b1, 1'b1, 1'b1, 1'b1);
    step("disable", 1'b0, 1'b1, 1'b1, 1'b0);

    step("dec00", 1'b0, 1'b0, 1'b0, 1'b1);
    check("sweep00_const", {h1, h2, h3, h4}, 4'b1000);
    step("dec01", 1'b0, 1'b0, 1'b1, 1'b1);
    check("sweep01_const", {h1, h2, h3, h4}, 4'b0100);
    check("pol01_const", {l1, l2, l3, l4}, 4'b1011);
    step("dec10", 1'b0, 1'b1, 1'b0, 1'b1);
    check("sweep10_const", {h1, h2, h3, h4}, 4'b0010);
    step("dec11", 1'b0, 1'b1, 1'b1, 1'b1);
    check("sweep11_const", {h1, h2, h3, h4}, 4'b0001);

    // Mid-cycle input change must not reach the outputs before the next edge
    step("hold_pre", 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    a = 1'b1;
    b = 1'b1;
    #2;
    check("hold_mid", {h1, h2, h3, h4}, 4'b1000);
    check("hold_mid_low", {l1, l2, l3, l4}, 4'b0111);

    step("b2b00", 1'b0, 1'b0, 1'b0, 1'b1);
    step("b2b11", 1'b0, 1'b1, 1'b1, 1'b1);
    step("b2b01", 1'b0, 1'b0, 1'b1, 1'b1);

    step("mid_pre", 1'b0, 1'b1, 1'b0, 1'b1);
    check("mid_pre_const", {h1, h2, h3, h4}, 4'b0010);
    step("mid_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_rst_const", {l1, l2, l3, l4}, 4'b1111);
    step("mid_rel", 1'b0, 1'b1, 1'b0, 1'b1);

    step("low_dis", 1'b0, 1'b0, 1'b1, 1'b0);
    check("low_dis_const", {l1, l2, l3, l4}, 4'b1111);

    for (int i = 0; i < 8; i++) begin
      step("en_toggle", 1'b0, 1'b1, 1'b0, 1'(i % 2));
    end

    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decoder_2x4.md
Name: decoder_2x4

Overview:
- Registered 2-to-4 line decoder with active-high enable.
- Inputs a, b form a 2-bit select code {a,b}, with a as the MSB.
- Exactly one of four outputs d1..d4 is driven active one clock after sampling while enabled; all outputs are inactive when disabled.
- Used as a small select/strobe generator for chip-select and mux-control paths in the datapath.

Parameters:
- ACTIVE_LOW_OUT, 0, output polarity. 0 = selected output is 1 and others 0. 1 = selected output is 0 and others 1.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous active-high reset
- a    input  1  select MSB
- b    input  1  select LSB
- en   input  1  active-high decode enable
- d1   output 1  active when {a,b}=2'b00 and en=1
- d2   output 1  active when {a,b}=2'b01 and en=1
- d3   output 1  active when {a,b}=2'b10 and en=1
- d4   output 1  active when {a,b}=2'b11 and en=1

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset path.
- All outputs are registered; there is no combinational input-to-output path.
- On every rising clk edge:
  - rst=1: d1..d4 load the inactive level (0 when ACTIVE_LOW_OUT=0, 1 when ACTIVE_LOW_OUT=1). rst has priority over en, a and b.
  - rst=0, en=0: d1..d4 load the inactive level regardless of a and b.
  - rst=0, en=1: the output indexed by {a,b} loads the active level; the other three load the inactive level.
- Latency: exactly 1 cycle from the sampled inputs to the outputs.
- Outputs hold between edges; input changes between edges have no effect until the next edge.
- Invariant: outside reset, at most one output is active at any time (one-hot or all-inactive).
- Reset mid-operation: outputs go inactive at the first edge with rst=1 and stay inactive while rst=1. Normal decode resumes on the first edge with rst=0, using the inputs sampled at that edge.
- Back-to-back code changes are decoded every cycle with no bubble.
- en toggling every cycle alternates between the decoded pattern and all-inactive with no hysteresis.
- X/Z on inputs: behaviour is undefined; the bench drives only known values.

Optional Feature:
- Macro: DECODER_2X4_STATUS_EN.
- When defined, two extra registered outputs are added:
  - sel_idx output 2: the {a,b} code latched on the last edge where rst=0 and en=1. Reset value 2'b00. Holds its value while en=0.
  - sel_vld output 1: registered copy of en. Reset value 0. Equals 1 exactly when one of d1..d4 is active.
- Both outputs share the 1-cycle latency of d1..d4.
- When not defined: the ports and their logic are absent, and d1..d4 behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1, b=1, en=1 -> d1..d4=0000 (ACTIVE_LOW_OUT=0); sel_vld=0, sel_idx=00 if enabled.
- Disable: rst=0, a=1, b=1, en=0 -> after 1 edge d1..d4=0000.
- Full decode sweep with en=1, checking each result one edge after drive:
  - {a,b}=00 -> d1..d4=1000
  - {a,b}=01 -> 0100
  - {a,b}=10 -> 0010
  - {a,b}=11 -> 0001
- Latency/hold: change a,b mid-cycle -> outputs unchanged until the next rising edge. Back-to-back codes 00,11,01 -> 1000, 0001, 0100 on consecutive edges.
- Reset mid-operation: en=1, {a,b}=10 giving d3=1; assert rst=1 for one edge -> 0000. Release rst -> 0010 on the next edge.
- Polarity: ACTIVE_LOW_OUT=1 -> reset gives 1111, en=0 gives 1111, {a,b}=01 with en=1 gives 1011.
